// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// mc_controller : multicycle control FSM (fetch/decode/execute/mem/writeback)
// Rev 1.0       : initial release
// ============================================================================
module mc_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADR  = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_RTYPEEX = 4'd6,
      ST_RTYPEWB = 4'd7,
      ST_BEQEX   = 4'd8,
      ST_ADDIEX  = 4'd9,
      ST_ADDIWB  = 4'd10,
      ST_JEX     = 4'd11
   } state_t;

   state_t r_state;
   state_t w_dec;
   state_t w_next;

   logic w_mem_req;
   logic w_memwrite;
   logic w_irwrite;
   logic w_regwrite;
   logic w_pcwrite;
   logic w_branch;
   logic w_illegal;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // While in reset every output decodes as FETCH, so a half-finished
   // instruction cannot leak a select or strobe into the datapath.
   assign w_dec = reset_n ? r_state : ST_FETCH;

   always_comb begin
      w_next     = ST_FETCH;
      w_mem_req  = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_illegal  = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;

      case (w_dec)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            alusrcb   = 2'b01;
            w_irwrite = mem_ready;
            w_pcwrite = mem_ready;
            w_next    = mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
               c_OP_RTYPE:       w_next = ST_RTYPEEX;
               c_OP_BEQ:         w_next = ST_BEQEX;
               c_OP_ADDI:        w_next = ST_ADDIEX;
               c_OP_J:           w_next = ST_JEX;
               default: begin
                  w_illegal = 1'b1;
                  w_next    = ST_FETCH;
               end
            endcase
         end
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = (op == c_OP_LW) ? ST_MEMRD : ST_MEMWR;
         end
         ST_MEMRD: begin
            w_mem_req = 1'b1;
            iord      = 1'b1;
            w_next    = mem_ready ? ST_MEMWB : ST_MEMRD;
         end
         ST_MEMWB: begin
            memtoreg   = 1'b1;
            w_regwrite = 1'b1;
         end
         ST_MEMWR: begin
            w_mem_req  = 1'b1;
            iord       = 1'b1;
            w_memwrite = 1'b1;
            w_next     = mem_ready ? ST_FETCH : ST_MEMWR;
         end
         ST_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            w_next  = ST_RTYPEWB;
         end
         ST_RTYPEWB: begin
            regdst     = 1'b1;
            w_regwrite = 1'b1;
         end
         ST_BEQEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            w_branch = 1'b1;
         end
         ST_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            w_regwrite = 1'b1;
         end
         ST_JEX: begin
            pcsrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: begin
            w_next = ST_FETCH;
         end
      endcase
   end

   assign mem_req    = reset_n & w_mem_req;
   assign memwrite   = reset_n & w_memwrite;
   assign irwrite    = reset_n & w_irwrite;
   assign regwrite   = reset_n & w_regwrite;
   assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
   assign illegal_op = reset_n & w_illegal;
   assign state      = w_dec;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_mc_controller : table-driven, scoreboarded check of mc_controller
// Rev 1.0          : initial release
// ============================================================================
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       pcen, illegal_op;
   logic [3:0] state;

   mc_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .illegal_op (illegal_op),
      .state      (state)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] c_LW = 6'b100011;
   localparam logic [5:0] c_SW = 6'b101011;
   localparam logic [5:0] c_R  = 6'b000000;
   localparam logic [5:0] c_BQ = 6'b000100;
   localparam logic [5:0] c_AD = 6'b001000;
   localparam logic [5:0] c_J  = 6'b000010;
   localparam logic [5:0] c_IL = 6'b111111;

   // Control word bit order, msb first:
   // mem_req iord memwrite irwrite | regdst memtoreg regwrite alusrca |
   // alusrcb[1:0] aluop[1:0] | pcsrc[1:0] pcen illegal_op
   localparam logic [15:0] c_RST  = 16'b0000_0000_0100_0000;
   localparam logic [15:0] c_F1   = 16'b1001_0000_0100_0010;
   localparam logic [15:0] c_F0   = 16'b1000_0000_0100_0000;
   localparam logic [15:0] c_DEC  = 16'b0000_0000_1100_0000;
   localparam logic [15:0] c_DIL  = 16'b0000_0000_1100_0001;
   localparam logic [15:0] c_MADR = 16'b0000_0001_1000_0000;
   localparam logic [15:0] c_MRD  = 16'b1100_0000_0000_0000;
   localparam logic [15:0] c_MWB  = 16'b0000_0110_0000_0000;
   localparam logic [15:0] c_MWR  = 16'b1110_0000_0000_0000;
   localparam logic [15:0] c_REX  = 16'b0000_0001_0010_0000;
   localparam logic [15:0] c_RWB  = 16'b0000_1010_0000_0000;
   localparam logic [15:0] c_BQ1  = 16'b0000_0001_0001_0110;
   localparam logic [15:0] c_BQ0  = 16'b0000_0001_0001_0100;
   localparam logic [15:0] c_AEX  = 16'b0000_0001_1000_0000;
   localparam logic [15:0] c_AWB  = 16'b0000_0010_0000_0000;
   localparam logic [15:0] c_JEX  = 16'b0000_0000_0000_1010;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [15:0] ctl;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic r, input logic [5:0] o, input logic z, input logic y,
                      input logic [3:0] s, input logic [15:0] c);
      vec_t v;
      v.rst_n = r; v.op = o; v.zero = z; v.rdy = y; v.st = s; v.ctl = c;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ctl_now();
      return {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, aluop, pcsrc, pcen, illegal_op};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t e;
      int   cnt;
      int   n;

      // reset, then lw with an op change while in MEMRD
      add(0, c_R , 0, 1, 0, c_RST); add(0, c_R , 0, 1, 0, c_RST);
      add(1, c_R , 0, 1, 0, c_F1 ); add(1, c_LW, 0, 1, 1, c_DEC);
      add(1, c_LW, 0, 1, 2, c_MADR); add(1, c_J , 0, 1, 3, c_MRD);
      add(1, c_J , 0, 1, 4, c_MWB);
      // sw with three wait cycles
      add(1, c_SW, 0, 1, 0, c_F1 ); add(1, c_SW, 0, 1, 1, c_DEC);
      add(1, c_SW, 0, 1, 2, c_MADR); add(1, c_SW, 0, 0, 5, c_MWR);
      add(1, c_SW, 0, 0, 5, c_MWR); add(1, c_SW, 0, 0, 5, c_MWR);
      add(1, c_SW, 0, 1, 5, c_MWR);
      // fetch wait, then R-type
      add(1, c_R , 0, 0, 0, c_F0 ); add(1, c_R , 0, 1, 0, c_F1 );
      add(1, c_R , 0, 1, 1, c_DEC); add(1, c_R , 0, 1, 6, c_REX);
      add(1, c_R , 0, 1, 7, c_RWB);
      // beq taken / not taken
      add(1, c_BQ, 1, 1, 0, c_F1 ); add(1, c_BQ, 1, 1, 1, c_DEC);
      add(1, c_BQ, 1, 1, 8, c_BQ1);
      add(1, c_BQ, 0, 1, 0, c_F1 ); add(1, c_BQ, 0, 1, 1, c_DEC);
      add(1, c_BQ, 0, 1, 8, c_BQ0);
      // addi, j, illegal
      add(1, c_AD, 0, 1, 0, c_F1 ); add(1, c_AD, 0, 1, 1, c_DEC);
      add(1, c_AD, 0, 1, 9, c_AEX); add(1, c_AD, 0, 1, 10, c_AWB);
      add(1, c_J , 0, 1, 0, c_F1 ); add(1, c_J , 0, 1, 1, c_DEC);
      add(1, c_J , 0, 1, 11, c_JEX);
      add(1, c_IL, 0, 1, 0, c_F1 ); add(1, c_IL, 0, 1, 1, c_DIL);
      add(1, c_IL, 0, 1, 0, c_F1 );
      // lw abandoned by reset while stalled in MEMRD
      add(1, c_LW, 0, 1, 1, c_DEC); add(1, c_LW, 0, 1, 2, c_MADR);
      add(1, c_LW, 0, 0, 3, c_MRD); add(0, c_LW, 0, 0, 0, c_RST);
      add(1, c_LW, 0, 0, 0, c_F0 ); add(1, c_LW, 0, 1, 0, c_F1 );

      foreach (vecs[i]) begin
         reset_n   = vecs[i].rst_n;
         op        = vecs[i].op;
         zero      = vecs[i].zero;
         mem_ready = vecs[i].rdy;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("row%0d_state", i), {28'd0, state}, {28'd0, e.st});
         chk($sformatf("row%0d_ctl", i), {16'd0, ctl_now()}, {16'd0, e.ctl});
         @(posedge clk); #1;
      end

      // store with a random number of memory wait cycles
      op = c_SW; zero = 1'b0; mem_ready = 1'b1; reset_n = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (state != 4'd2 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("sw_reach_memadr", {28'd0, state}, 32'd2);
      n = $urandom_range(1, 5);
      mem_ready = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("sw_wait_state", {28'd0, state}, 32'd5);
         chk("sw_wait_memwrite", {31'd0, memwrite}, 32'd1);
         chk("sw_wait_iord", {31'd0, iord}, 32'd1);
         chk("sw_wait_regwrite", {31'd0, regwrite}, 32'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("sw_done_state", {28'd0, state}, 32'd5);
      chk("sw_done_memwrite", {31'd0, memwrite}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_after_state", {28'd0, state}, 32'd0);
      chk("sw_after_memwrite", {31'd0, memwrite}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
